// File: rtl/trap_psr_sequencer.sv
// Trap entry / RETT exit sequencer driving single-field PSR writes.
// Ports: clk, rst (async low), request/ack handshakes, PSR readback and strobes, tt latch.
module trap_psr_sequencer #(
  parameter int NWINDOWS = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       trap_req,
  input  logic [7:0] trap_tt,
  input  logic       rett_req,
  input  logic       S_cur,
  input  logic       PS_cur,
  input  logic       ET_cur,
  input  logic [4:0] CWP_cur,
  output logic       trap_ack,
  output logic       rett_ack,
  output logic       rett_err,
  output logic       busy,
  output logic       done,
  output logic       error_mode,
  output logic       PS_set,
  output logic       PS_in,
  output logic       S_set,
  output logic       S_in,
  output logic       ET_set,
  output logic       ET_in,
  output logic       CWP_wr,
  output logic [4:0] CWP_in,
  output logic       tt_wr,
  output logic [7:0] tt_out
);

  typedef enum logic [3:0] {
    IDLE,
    T_PS,
    T_S,
    T_ET,
    T_CWP,
    T_TT,
    R_CWP,
    R_S,
    R_ET,
    ERROR
  } state_t;

  localparam logic [4:0] CWP_MAX = 5'(NWINDOWS - 1);
  localparam logic [5:0] CWP_LIM = 6'(NWINDOWS);

  state_t     state;
  logic       snap_s;
  logic       snap_ps;
  logic [4:0] snap_cwp;
  logic [7:0] snap_tt;
  logic [4:0] cwp_dec;
  logic [4:0] cwp_inc;
  logic [4:0] cwp_safe;

  // Out-of-range readback is clamped so the wrap logic
  // can never emit a CWP at or above NWINDOWS.
  always_comb begin
    cwp_safe = CWP_cur;
    if ({1'b0, CWP_cur} >= CWP_LIM)
      cwp_safe = CWP_MAX;
  end

  always_comb begin
    cwp_dec = snap_cwp - 5'd1;
    if (snap_cwp == 5'd0)
      cwp_dec = CWP_MAX;
  end

  always_comb begin
    cwp_inc = snap_cwp + 5'd1;
    if (snap_cwp == CWP_MAX)
      cwp_inc = 5'd0;
  end

  // Outputs are registered one edge after the state that
  // owns them, so each strobe lands in its own cycle and
  // trails the ack by exactly one cycle.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      snap_s     <= 1'b0;
      snap_ps    <= 1'b0;
      snap_cwp   <= 5'd0;
      snap_tt    <= 8'd0;
      trap_ack   <= 1'b0;
      rett_ack   <= 1'b0;
      rett_err   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error_mode <= 1'b0;
      PS_set     <= 1'b0;
      PS_in      <= 1'b0;
      S_set      <= 1'b0;
      S_in       <= 1'b0;
      ET_set     <= 1'b0;
      ET_in      <= 1'b0;
      CWP_wr     <= 1'b0;
      CWP_in     <= 5'd0;
      tt_wr      <= 1'b0;
      tt_out     <= 8'd0;
    end else begin
      trap_ack <= 1'b0;
      rett_ack <= 1'b0;
      rett_err <= 1'b0;
      done     <= 1'b0;
      PS_set   <= 1'b0;
      PS_in    <= 1'b0;
      S_set    <= 1'b0;
      S_in     <= 1'b0;
      ET_set   <= 1'b0;
      ET_in    <= 1'b0;
      CWP_wr   <= 1'b0;
      CWP_in   <= 5'd0;
      tt_wr    <= 1'b0;
      unique case (state)
        IDLE: begin
          busy <= 1'b0;
          if (trap_req) begin
            trap_ack <= 1'b1;
            if (ET_cur) begin
              snap_s   <= S_cur;
              snap_cwp <= cwp_safe;
              snap_tt  <= trap_tt;
              busy     <= 1'b1;
              state    <= T_PS;
            end else begin
              // Trap with traps disabled: halt.
              error_mode <= 1'b1;
              state      <= ERROR;
            end
          end else if (rett_req) begin
            rett_ack <= 1'b1;
            if (!ET_cur) begin
              snap_ps  <= PS_cur;
              snap_cwp <= cwp_safe;
              busy     <= 1'b1;
              state    <= R_CWP;
            end else begin
              rett_err <= 1'b1;
            end
          end
        end
        T_PS: begin
          busy   <= 1'b1;
          PS_set <= 1'b1;
          PS_in  <= snap_s;
          state  <= T_S;
        end
        T_S: begin
          busy  <= 1'b1;
          S_set <= 1'b1;
          S_in  <= 1'b1;
          state <= T_ET;
        end
        T_ET: begin
          busy   <= 1'b1;
          ET_set <= 1'b1;
          ET_in  <= 1'b0;
          state  <= T_CWP;
        end
        T_CWP: begin
          busy   <= 1'b1;
          CWP_wr <= 1'b1;
          CWP_in <= cwp_dec;
          state  <= T_TT;
        end
        T_TT: begin
          // busy stays high for the done cycle; the
          // IDLE visit that follows samples requests.
          busy   <= 1'b1;
          tt_wr  <= 1'b1;
          tt_out <= snap_tt;
          done   <= 1'b1;
          state  <= IDLE;
        end
        R_CWP: begin
          busy   <= 1'b1;
          CWP_wr <= 1'b1;
          CWP_in <= cwp_inc;
          state  <= R_S;
        end
        R_S: begin
          busy  <= 1'b1;
          S_set <= 1'b1;
          S_in  <= snap_ps;
          state <= R_ET;
        end
        R_ET: begin
          busy   <= 1'b1;
          ET_set <= 1'b1;
          ET_in  <= 1'b1;
          done   <= 1'b1;
          state  <= IDLE;
        end
        ERROR: begin
          busy       <= 1'b0;
          error_mode <= 1'b1;
          state      <= ERROR;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_trap_psr_sequencer.sv
// Directed bench for trap_psr_sequencer.
// Hand-computed vectors; one check task; strobe exclusivity monitor.
module tb_trap_psr_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       trap_req;
  logic [7:0] trap_tt;
  logic       rett_req;
  logic       S_cur;
  logic       PS_cur;
  logic       ET_cur;
  logic [4:0] CWP_cur;
  logic       trap_ack;
  logic       rett_ack;
  logic       rett_err;
  logic       busy;
  logic       done;
  logic       error_mode;
  logic       PS_set;
  logic       PS_in;
  logic       S_set;
  logic       S_in;
  logic       ET_set;
  logic       ET_in;
  logic       CWP_wr;
  logic [4:0] CWP_in;
  logic       tt_wr;
  logic [7:0] tt_out;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  trap_psr_sequencer #(.NWINDOWS(8)) dut (
    .clk(clk), .rst(rst),
    .trap_req(trap_req), .trap_tt(trap_tt),
    .rett_req(rett_req),
    .S_cur(S_cur), .PS_cur(PS_cur),
    .ET_cur(ET_cur), .CWP_cur(CWP_cur),
    .trap_ack(trap_ack), .rett_ack(rett_ack),
    .rett_err(rett_err), .busy(busy),
    .done(done), .error_mode(error_mode),
    .PS_set(PS_set), .PS_in(PS_in),
    .S_set(S_set), .S_in(S_in),
    .ET_set(ET_set), .ET_in(ET_in),
    .CWP_wr(CWP_wr), .CWP_in(CWP_in),
    .tt_wr(tt_wr), .tt_out(tt_out)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] strobes();
    return {PS_set, S_set, ET_set, CWP_wr};
  endfunction

  always @(negedge clk) begin
    if (rst)
      chk("one_strobe",
          32'(PS_set) + 32'(S_set) + 32'(ET_set) + 32'(CWP_wr) <= 1,
          1);
  end

  task automatic run_trap(input logic [7:0] tt,
                          input logic s,
                          input logic [4:0] cwp,
                          input logic exp_ps,
                          input logic [4:0] exp_cwp);
    trap_req = 1'b1;
    trap_tt  = tt;
    S_cur    = s;
    ET_cur   = 1'b1;
    CWP_cur  = cwp;
    tick();
    chk("t_ack", trap_ack, 1);
    chk("t_ack_busy", busy, 1);
    chk("t_ack_nostb", strobes(), 0);
    chk("t_ack_rett", rett_ack, 0);
    trap_req = 1'b0;
    trap_tt  = 8'hee;
    S_cur    = ~s;
    ET_cur   = 1'b0;
    tick();
    chk("t_ps_stb", strobes(), 4'b1000);
    chk("t_ps_val", PS_in, exp_ps);
    chk("t_ps_ack", trap_ack, 0);
    tick();
    chk("t_s_stb", strobes(), 4'b0100);
    chk("t_s_val", S_in, 1);
    tick();
    chk("t_et_stb", strobes(), 4'b0010);
    chk("t_et_val", ET_in, 0);
    chk("t_et_busy", busy, 1);
    tick();
    chk("t_cwp_stb", strobes(), 4'b0001);
    chk("t_cwp_val", CWP_in, exp_cwp);
    chk("t_cwp_done", done, 0);
    tick();
    chk("t_tt_stb", strobes(), 0);
    chk("t_tt_wr", tt_wr, 1);
    chk("t_tt_val", tt_out, tt);
    chk("t_done", done, 1);
    chk("t_done_rett", rett_ack, 0);
  endtask

  task automatic run_rett(input logic ps,
                          input logic [4:0] cwp,
                          input logic [4:0] exp_cwp,
                          input logic exp_s);
    rett_req = 1'b1;
    PS_cur   = ps;
    ET_cur   = 1'b0;
    CWP_cur  = cwp;
    tick();
    chk("r_ack", rett_ack, 1);
    chk("r_err", rett_err, 0);
    chk("r_ack_nostb", strobes(), 0);
    rett_req = 1'b0;
    PS_cur   = ~ps;
    CWP_cur  = 5'd1;
    tick();
    chk("r_cwp_stb", strobes(), 4'b0001);
    chk("r_cwp_val", CWP_in, exp_cwp);
    tick();
    chk("r_s_stb", strobes(), 4'b0100);
    chk("r_s_val", S_in, exp_s);
    tick();
    chk("r_et_stb", strobes(), 4'b0010);
    chk("r_et_val", ET_in, 1);
    chk("r_done", done, 1);
    ET_cur = 1'b1;
  endtask

  initial begin
    rst      = 1'b0;
    trap_req = 1'b0;
    trap_tt  = 8'h00;
    rett_req = 1'b0;
    S_cur    = 1'b0;
    PS_cur   = 1'b0;
    ET_cur   = 1'b1;
    CWP_cur  = 5'd0;
    tick();
    tick();
    chk("rst_stb", strobes(), 0);
    chk("rst_busy", busy, 0);
    chk("rst_tt", tt_out, 0);
    chk("rst_acks", {trap_ack, rett_ack, rett_err, done, error_mode, tt_wr}, 0);
    rst = 1'b1;
    tick();

    // basic trap entry
    run_trap(8'h11, 1'b0, 5'd3, 1'b0, 5'd2);
    tick();
    chk("post_done", done, 0);
    chk("post_ttwr", tt_wr, 0);
    chk("tt_hold", tt_out, 8'h11);
    chk("post_busy", busy, 0);

    // window wrap both directions
    run_trap(8'h05, 1'b1, 5'd0, 1'b1, 5'd7);
    tick();
    run_rett(1'b1, 5'd7, 5'd0, 1'b1);
    tick();

    // normal and rejected RETT
    run_rett(1'b0, 5'd5, 5'd6, 1'b0);
    tick();
    rett_req = 1'b1;
    ET_cur   = 1'b1;
    tick();
    chk("rej_ack", rett_ack, 1);
    chk("rej_err", rett_err, 1);
    chk("rej_busy", busy, 0);
    rett_req = 1'b0;
    tick();
    chk("rej_ack_off", {rett_ack, rett_err}, 0);
    chk("rej_nostb", strobes(), 0);
    chk("rej_done", done, 0);

    // trap wins over held RETT, which is acked after done
    rett_req = 1'b1;
    run_trap(8'h22, 1'b1, 5'd4, 1'b1, 5'd3);
    run_rett(1'b1, 5'd3, 5'd4, 1'b1);
    tick();

    // trap with ET=0 -> error mode
    trap_req = 1'b1;
    ET_cur   = 1'b0;
    tick();
    chk("err_ack", trap_ack, 1);
    trap_req = 1'b0;
    tick();
    chk("err_mode", error_mode, 1);
    chk("err_busy", busy, 0);
    trap_req = 1'b1;
    rett_req = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("err_noack", {trap_ack, rett_ack}, 0);
      chk("err_nostb", {strobes(), tt_wr}, 0);
      chk("err_hold", error_mode, 1);
    end
    trap_req = 1'b0;
    rett_req = 1'b0;
    rst = 1'b0;
    #1;
    chk("err_clr", error_mode, 0);
    tick();
    rst = 1'b1;
    tick();

    // reset in the middle of trap entry
    trap_req = 1'b1;
    ET_cur   = 1'b1;
    CWP_cur  = 5'd2;
    tick();
    chk("ab_ack", trap_ack, 1);
    trap_req = 1'b0;
    tick();
    tick();
    tick();
    chk("ab_et", ET_set, 1);
    #2;
    rst = 1'b0;
    #1;
    chk("ab_stb", strobes(), 0);
    chk("ab_busy", busy, 0);
    tick();
    rst = 1'b1;
    tick();
    run_trap(8'h33, 1'b0, 5'd6, 1'b0, 5'd5);
    tick();
    chk("end_busy", busy, 0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1);
  end

endmodule
